// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the SR latch sequencing controller.
package sr_latch_pkg;

  // Widths of the pulse and settle down-counters.
  localparam int PULSE_W  = 4;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_ACK
  } state_t;

endpackage

// File: rtl/sr_cell.sv
// Clocked SR latch model. S=R=1 is treated as illegal and holds state.
module sr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qb
);

  // Latch storage: set, reset or hold; q and qb always move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else if (s && !r) begin
      q  <= 1'b1;
      qb <= 1'b0;
    end else if (r && !s) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Round-robin arbitrated sequencer that pulses an SR latch to each
// requester's target value, waits for it to settle, reads it back and acks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitration happens here
//   ST_PULSE  | driving s_o or r_o for PULSE_CYC cycles
//   ST_SETTLE | s_o=r_o=0 for SETTLE_CYC cycles before readback
//   ST_CHECK  | compare latch Q with the granted target, flag err on mismatch
//   ST_ACK    | schedule the one-cycle ack to the granted requester
module sr_latch_ctrl
  import sr_latch_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         op,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     s_o,
  output logic                     r_o,
  output logic                     q_o,
  output logic                     qb_o,
  output logic                     err
);

  localparam int GW = $clog2(N_REQ);

  state_t              state;
  logic                op_q;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                q_cell;
  logic                qb_cell;
  logic                rr_hit;
  logic [GW-1:0]       rr_idx;
  logic [GW-1:0]       rr_cand;

  // Round-robin pick: first requester after the last grant, wrapping at N_REQ.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = '0;
    rr_cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_cand = GW'((int'(grant_id) + i) % N_REQ);
      if (!rr_hit && req[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  // Sequencing FSM with registered outputs and pulse/settle down-counters.
  // ack is issued on the edge leaving ST_ACK, so it is high during the first
  // IDLE cycle; arbitration is held off in that cycle so the requester has a
  // cycle to drop req before it is seen as a new request.
  // A target that already matches Q skips the pulse but still takes the
  // CHECK cycle, so every operation ends with a readback before its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_id   <= GW'(N_REQ - 1);
      op_q       <= 1'b0;
      pulse_cnt  <= '0;
      settle_cnt <= '0;
      s_o        <= 1'b0;
      r_o        <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (rr_hit && (ack == '0)) begin
            grant_id <= rr_idx;
            op_q     <= op[rr_idx];
            busy     <= 1'b1;
            if (q_cell == op[rr_idx]) begin
              state <= ST_CHECK;
            end else begin
              state     <= ST_PULSE;
              pulse_cnt <= PULSE_W'(PULSE_CYC - 1);
              s_o       <= op[rr_idx];
              r_o       <= ~op[rr_idx];
            end
          end
        end
        ST_PULSE: begin
          if (pulse_cnt == '0) begin
            s_o <= 1'b0;
            r_o <= 1'b0;
            if (SETTLE_CYC == 0) begin
              state <= ST_CHECK;
            end else begin
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
            end
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_CHECK;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        ST_CHECK: begin
          if (q_cell != op_q) err <= 1'b1;
          state <= ST_ACK;
        end
        ST_ACK: begin
          ack[grant_id] <= 1'b1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sr_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s_o),
    .r     (r_o),
    .q     (q_cell),
    .qb    (qb_cell)
  );

  assign q_o  = q_cell;
  assign qb_o = qb_cell;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: table vectors, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_sr_latch_ctrl;

  localparam int P1 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [3:0] req, op, req2, op2;
  logic [3:0] ack, ack2;
  logic [1:0] grant_id, grant_id2;
  logic       busy, busy2, s_o, s2, r_o, r2, q_o, q2, qb_o, qb2, err, err2;

  always #5 clk = ~clk;

  sr_latch_ctrl #(.N_REQ(4), .PULSE_CYC(P1), .SETTLE_CYC(S1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ack(ack),
    .grant_id(grant_id), .busy(busy), .s_o(s_o), .r_o(r_o),
    .q_o(q_o), .qb_o(qb_o), .err(err)
  );

  sr_latch_ctrl #(.N_REQ(4), .PULSE_CYC(1), .SETTLE_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .op(op2), .ack(ack2),
    .grant_id(grant_id2), .busy(busy2), .s_o(s2), .r_o(r2),
    .q_o(q2), .qb_o(qb2), .err(err2)
  );

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  bit mon_en   = 0;

  // Reference model state: latch value, last granted requester.
  int m_q, m_last;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] ov;
    int g, lat, sc, rc, q;
  } vec_t;

  always @(negedge clk) begin
    if (mon_en) begin
      if (s_o && r_o) viol++;
      if (s2 && r2) viol++;
      if (qb_o !== ~q_o) viol++;
      if (qb2 !== ~q2) viol++;
      if ($countones(ack) > 1 || $countones(ack2) > 1) viol++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] rv, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (rv[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; op = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_q = 0; m_last = 3;
  endtask

  // One request transaction: drive at negedge, the next posedge samples it,
  // then count edges until ack and the s_o/r_o high cycles on the way.
  task automatic run_txn(input bit sel, input logic [3:0] rv, input logic [3:0] ov,
                         input bit drop, output int g, output int lat,
                         output int sc, output int rc, output int av);
    @(negedge clk);
    if (sel) begin req2 = rv; op2 = ov; end
    else begin req = rv; op = ov; end
    @(posedge clk); #1;
    sc = sel ? int'(s2) : int'(s_o);
    rc = sel ? int'(r2) : int'(r_o);
    lat = -1; g = -1; av = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (drop) begin
        if (sel) req2 = '0; else req = '0;
      end
      if ((sel ? ack2 : ack) != '0) begin
        lat = k;
        g   = sel ? int'(grant_id2) : int'(grant_id);
        av  = sel ? int'(ack2) : int'(ack);
        break;
      end
      sc += sel ? int'(s2) : int'(s_o);
      rc += sel ? int'(r2) : int'(r_o);
    end
    if (sel) req2 = '0; else req = '0;
    @(posedge clk);
  endtask

  initial begin
    vec_t vt[8];
    int g, lat, sc, rc, av, got, eg, elat, es, er, tgt;
    logic [3:0] rv, ov;
    int seq_exp[9];

    vt[0] = '{4'b0001, 4'b0001, 0, 5, 2, 0, 1};
    vt[1] = '{4'b0100, 4'b0100, 2, 2, 0, 0, 1};
    vt[2] = '{4'b1111, 4'b0000, 3, 5, 0, 2, 0};
    vt[3] = '{4'b1111, 4'b0000, 0, 2, 0, 0, 0};
    vt[4] = '{4'b1111, 4'b1111, 1, 5, 2, 0, 1};
    vt[5] = '{4'b1111, 4'b0000, 2, 5, 0, 2, 0};
    vt[6] = '{4'b1010, 4'b1010, 3, 5, 2, 0, 1};
    vt[7] = '{4'b0001, 4'b0000, 0, 5, 0, 2, 0};
    seq_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    rst_n = 1'b0; rst2_n = 1'b0;
    req = '0; op = '0; req2 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_q", q_o, 0);
    chk("rst_qb", qb_o, 1);
    chk("rst_s_r_ack", {s_o, r_o, ack}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    mon_en = 1;

    // Directed table from reset.
    for (int i = 0; i < 8; i++) begin
      run_txn(0, vt[i].rv, vt[i].ov, 0, g, lat, sc, rc, av);
      chk($sformatf("tbl%0d_grant", i), g, vt[i].g);
      chk($sformatf("tbl%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("tbl%0d_s_cnt", i), sc, vt[i].sc);
      chk($sformatf("tbl%0d_r_cnt", i), rc, vt[i].rc);
      chk($sformatf("tbl%0d_ack", i), av, 1 << vt[i].g);
      chk($sformatf("tbl%0d_q", i), q_o, vt[i].q);
      chk($sformatf("tbl%0d_err", i), err, 0);
    end

    // All requesters held high: strict rotation, then targets toggled.
    do_reset();
    @(negedge clk); req = 4'hF; op = 4'h0;
    for (int t = 0; t < 9; t++) begin
      if (t == 5) begin
        @(negedge clk); req = '0;
        @(negedge clk); op = 4'hF; req = 4'hF;
      end
      got = -1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (ack != '0) begin got = grant_id; av = ack; break; end
      end
      chk($sformatf("rot%0d_grant", t), got, seq_exp[t]);
      chk($sformatf("rot%0d_ack", t), av, 1 << seq_exp[t]);
    end
    chk("rot_q_after_toggle", q_o, 1);
    req = '0;
    @(posedge clk);

    // Randomized transactions against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      rv = 4'($urandom_range(1, 15));
      ov = 4'($urandom);
      eg = rr_pick(rv, m_last);
      tgt = int'(ov[eg]);
      if (tgt == m_q) begin elat = 2; es = 0; er = 0; end
      else begin elat = P1 + S1 + 2; es = tgt ? P1 : 0; er = tgt ? 0 : P1; end
      m_q = tgt; m_last = eg;
      run_txn(0, rv, ov, ($urandom_range(0, 3) == 0), g, lat, sc, rc, av);
      chk($sformatf("rnd%0d_grant", n), g, eg);
      chk($sformatf("rnd%0d_lat", n), lat, elat);
      chk($sformatf("rnd%0d_s_cnt", n), sc, es);
      chk($sformatf("rnd%0d_r_cnt", n), rc, er);
      chk($sformatf("rnd%0d_q", n), q_o, m_q);
      chk($sformatf("rnd%0d_err", n), err, 0);
    end

    // Reset in the middle of a pulse aborts without ack.
    do_reset();
    @(negedge clk); req = 4'b0010; op = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_s_before", s_o, 1);
    chk("abort_q_before", q_o, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_s_drop", s_o, 0);
    chk("abort_q_cleared", q_o, 0);
    chk("abort_busy", busy, 0);
    chk("abort_grant_id", grant_id, 3);
    got = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack != '0) got++;
    end
    chk("abort_no_ack", got, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    lat = -1; got = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack != '0) begin lat = k; got = grant_id; break; end
    end
    chk("abort_regrant_id", got, 1);
    chk("abort_regrant_lat", lat, P1 + S1 + 2);
    req = '0;
    @(posedge clk);

    // Latch stuck low: readback mismatch sets a sticky err.
    do_reset();
    mon_en = 0;
    force dut.u_cell.q = 1'b0;
    force dut.u_cell.qb = 1'b1;
    run_txn(0, 4'b0001, 4'b0001, 0, g, lat, sc, rc, av);
    chk("stuck_lat", lat, P1 + S1 + 2);
    chk("stuck_err", err, 1);
    release dut.u_cell.q;
    release dut.u_cell.qb;
    @(negedge clk);
    mon_en = 1;
    run_txn(0, 4'b0010, 4'b0010, 0, g, lat, sc, rc, av);
    chk("stuck_good_set_q", q_o, 1);
    chk("stuck_err_sticky1", err, 1);
    run_txn(0, 4'b0100, 4'b0000, 0, g, lat, sc, rc, av);
    chk("stuck_good_clr_q", q_o, 0);
    chk("stuck_err_sticky2", err, 1);
    do_reset();
    #1;
    chk("stuck_err_cleared", err, 0);

    // Minimum timing: one-cycle pulse, no settle.
    run_txn(1, 4'b0001, 4'b0001, 0, g, lat, sc, rc, av);
    chk("fast_set_lat", lat, 3);
    chk("fast_set_s_cnt", sc, 1);
    chk("fast_set_q", q2, 1);
    run_txn(1, 4'b0010, 4'b0000, 0, g, lat, sc, rc, av);
    chk("fast_clr_lat", lat, 3);
    chk("fast_clr_r_cnt", rc, 1);
    chk("fast_clr_grant", g, 1);
    chk("fast_clr_q", q2, 0);
    chk("fast_err_busy", {err2, busy2}, 0);

    chk("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
